// File: rtl/attention_pkg.sv
// attention_pkg: FP32 constants and the normalization FSM state encoding
package attention_pkg;
  localparam logic [31:0] FP32_PZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SUM,
    S_WAIT_SUM,
    S_RD_E,
    S_WAIT_E,
    S_DIV,
    S_WAIT_DIV,
    S_DONE
  } norm_state_e;
endpackage

// File: rtl/fp_div_driver_ba.sv
// fp_div_driver_ba: iterative FP32 divider z=a/b (RNE, subnormals flushed); start->busy->one-cycle done with z_bits
module fp_div_driver_ba
  import attention_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_bits,
  input  logic [31:0] b_bits,
  output logic        busy,
  output logic        done,
  output logic [31:0] z_bits
);
  logic [31:0] a_r, b_r;
  logic [24:0] rem, diff, mr;
  logic [23:0] mb, m;
  logic [25:0] q;
  logic [4:0] cnt;
  logic run, ge, s, q_hi, g, st, nan, inf, zer;
  logic signed [9:0] e, ef;
  logic [22:0] frac;
  logic [31:0] res;
  assign busy = run;
  assign ge = rem >= {1'b0, mb};
  assign diff = ge ? rem - {1'b0, mb} : rem;
  assign s = a_r[31] ^ b_r[31];
  assign nan = (&a_r[30:23] & |a_r[22:0]) | (&b_r[30:23] & |b_r[22:0])
             | (&a_r[30:23] & &b_r[30:23]) | (~|a_r[30:23] & ~|b_r[30:23]);
  assign inf = &a_r[30:23] | ~|b_r[30:23];
  assign zer = ~|a_r[30:23] | &b_r[30:23];
  assign q_hi = q[25];
  assign m = q_hi ? q[25:2] : q[24:1];
  assign g = q_hi ? q[1] : q[0];
  assign st = (q_hi & q[0]) | |rem;
  assign e = $signed({2'b0, a_r[30:23]}) - $signed({2'b0, b_r[30:23]}) + 10'sd126 + $signed({9'd0, q_hi});
  assign mr = {1'b0, m} + {24'd0, g & (st | m[0])};
  assign ef = e + $signed({9'd0, mr[24]});
  assign frac = mr[24] ? 23'd0 : mr[22:0];
  assign res = nan ? FP32_QNAN : inf ? {s, 8'hFF, 23'd0} : zer ? {s, 31'd0}
             : ef > 10'sd254 ? {s, 8'hFF, 23'd0} : ef < 10'sd1 ? {s, 31'd0} : {s, ef[7:0], frac};
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      done <= 1'b0;
      z_bits <= '0;
      cnt <= '0;
      rem <= '0;
      mb <= '0;
      q <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      done <= 1'b0;
      if (!run && start) begin
        run <= 1'b1;
        cnt <= '0;
        a_r <= a_bits;
        b_r <= b_bits;
        rem <= {2'b01, a_bits[22:0]};
        mb <= {1'b1, b_bits[22:0]};
        q <= '0;
      end else if (run) begin
        if (cnt == 5'd26) begin
          run <= 1'b0;
          done <= 1'b1;
          z_bits <= res;
        end else begin
          rem <= {diff[23:0], 1'b0};
          q <= {q[24:0], ge};
          cnt <= cnt + 5'd1;
        end
      end
    end
  end
endmodule

// File: rtl/attention_softmax_norm.sv
// attention_softmax_norm: P[r][k]=E[r][k]/Sum[r] via upstream read ports and a shared divider; P readable any time with 1-cycle latency
module attention_softmax_norm
  import attention_pkg::*;
#(
  parameter int T = 8,
  parameter int DATA_W = 32,
  localparam int T_W = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sum_re,
  output logic [T_W-1:0]    sum_row,
  input  logic [DATA_W-1:0] sum_rdata,
  input  logic              sum_rvalid,
  output logic              e_re,
  output logic [T_W-1:0]    e_tq,
  output logic [T_W-1:0]    e_tk,
  input  logic [DATA_W-1:0] e_rdata,
  input  logic              e_rvalid,
  input  logic              p_re,
  input  logic [T_W-1:0]    p_tq,
  input  logic [T_W-1:0]    p_tk,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid,
  output logic [T-1:0]      zero_row
);
  norm_state_e state;
  logic [T_W-1:0] r, k;
  logic [DATA_W-1:0] sum_hold, e_hold;
  logic [DATA_W-1:0] p_mem [T][T];
  logic div_busy, div_done, sum_zero, last_k, last_r, adv;
  logic [31:0] div_z;
  assign sum_zero = sum_hold[30:0] == '0;
  assign last_k = k == T_W'(T - 1);
  assign last_r = r == T_W'(T - 1);
  assign adv = (state == S_RD_E && sum_zero) || (state == S_WAIT_DIV && div_done);
  assign busy = !(state == S_IDLE || state == S_DONE);
  assign done = state == S_DONE;
  assign sum_re = state == S_RD_SUM;
  assign e_re = state == S_RD_E && !sum_zero;
  assign sum_row = r;
  assign e_tq = r;
  assign e_tk = k;
  fp_div_driver_ba u_div (
    .clk(clk),
    .rst(rst),
    .start(state == S_DIV && !div_busy),
    .a_bits(e_hold),
    .b_bits(sum_hold),
    .busy(div_busy),
    .done(div_done),
    .z_bits(div_z)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      r <= '0;
      k <= '0;
      sum_hold <= '0;
      e_hold <= '0;
      zero_row <= '0;
      p_rvalid <= 1'b0;
      p_rdata <= '0;
      for (int i = 0; i < T; i++)
        for (int j = 0; j < T; j++)
          p_mem[i][j] <= FP32_PZERO;
    end else begin
      p_rvalid <= p_re;
      if (p_re) p_rdata <= p_mem[p_tq][p_tk];
      case (state)
        S_IDLE: if (start) begin
          state <= S_RD_SUM;
          r <= '0;
          k <= '0;
          zero_row <= '0;
        end
        S_RD_SUM: state <= S_WAIT_SUM;
        S_WAIT_SUM: if (sum_rvalid) begin
          sum_hold <= sum_rdata;
          state <= S_RD_E;
          if (sum_rdata[30:0] == '0) zero_row[r] <= 1'b1;
        end
        S_RD_E: if (!sum_zero) state <= S_WAIT_E;
        S_WAIT_E: if (e_rvalid) begin
          e_hold <= e_rdata;
          state <= S_DIV;
        end
        S_DIV: state <= S_WAIT_DIV;
        S_WAIT_DIV: ;
        S_DONE: if (!start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (adv) begin
        p_mem[r][k] <= sum_zero ? FP32_PZERO : div_z;
        state <= last_k ? (last_r ? S_DONE : S_RD_SUM) : S_RD_E;
        k <= last_k ? '0 : k + T_W'(1);
        r <= (last_k && !last_r) ? r + T_W'(1) : r;
      end
    end
  end
endmodule

// File: tb/tb_attention_softmax_norm.sv
// tb_attention_softmax_norm: directed, table-driven self-checking bench with latency-configurable upstream models
module tb_attention_softmax_norm;
  localparam int T = 8;
  localparam int TW = 3;
  typedef struct {
    int tq;
    int tk;
    logic [31:0] e;
    logic [31:0] p;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, sum_re, e_re, p_rvalid;
  logic p_re = 1'b0, sum_rvalid = 1'b0, e_rvalid = 1'b0;
  logic [TW-1:0] sum_row, e_tq, e_tk;
  logic [TW-1:0] p_tq = '0, p_tk = '0;
  logic [31:0] sum_rdata = '0, e_rdata = '0, p_rdata;
  logic [T-1:0] zero_row;
  logic [31:0] e_mem [T][T];
  logic [31:0] s_mem [T];
  logic [31:0] exp_p [T][T];
  logic [31:0] row_exp [T];
  vec_t vecs [10];
  int checks = 0, errors = 0;
  int e_lat = 1, s_lat = 1, e_cnt = 0, s_cnt = 0;
  int proto_err = 0, e5_cnt = 0, sre_cnt = 0;
  logic prev_e = 1'b0, prev_s = 1'b0;
  logic [TW-1:0] eq = '0, ek = '0, sr = '0;
  always #5 clk = ~clk;
  attention_softmax_norm #(.T(T), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sum_re(sum_re), .sum_row(sum_row), .sum_rdata(sum_rdata), .sum_rvalid(sum_rvalid),
    .e_re(e_re), .e_tq(e_tq), .e_tk(e_tk), .e_rdata(e_rdata), .e_rvalid(e_rvalid),
    .p_re(p_re), .p_tq(p_tq), .p_tk(p_tk), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .zero_row(zero_row)
  );
  always @(negedge clk) begin
    e_rvalid = 1'b0;
    sum_rvalid = 1'b0;
    if (e_cnt > 0) begin
      e_cnt--;
      if (e_cnt == 0) begin
        e_rvalid = 1'b1;
        e_rdata = e_mem[eq][ek];
      end
    end
    if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) begin
        sum_rvalid = 1'b1;
        sum_rdata = s_mem[sr];
      end
    end
    if (e_re) begin
      if (prev_e || e_cnt > 0) proto_err++;
      if (e_tq == 3'd5) e5_cnt++;
      e_cnt = e_lat;
      eq = e_tq;
      ek = e_tk;
    end
    if (sum_re) begin
      if (prev_s || s_cnt > 0) proto_err++;
      sre_cnt++;
      s_cnt = s_lat;
      sr = sum_row;
    end
    prev_e = e_re;
    prev_s = sum_re;
  end
  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask
  task automatic read_p(input int tq, input int tk, output logic [32:0] res);
    @(negedge clk);
    p_re = 1'b1;
    p_tq = TW'(tq);
    p_tk = TW'(tk);
    @(negedge clk);
    p_re = 1'b0;
    res = {p_rvalid, p_rdata};
  endtask
  task automatic chk_all(input string nm);
    logic [32:0] res;
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        read_p(i, j, res);
        chk($sformatf("%s P[%0d][%0d]", nm, i, j), res, {1'b1, exp_p[i][j]});
      end
    @(negedge clk);
    chk({nm, " p_rvalid idle"}, 33'(p_rvalid), 33'd0);
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done"}, 33'(done), 33'd1);
  endtask
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic fill_plain();
    for (int i = 0; i < T; i++) begin
      s_mem[i] = 32'h4100_0000;
      for (int j = 0; j < T; j++) begin
        e_mem[i][j] = 32'h3F80_0000;
        exp_p[i][j] = 32'h3E00_0000;
      end
    end
  endtask
  task automatic fill_mixed();
    s_mem = '{32'h4100_0000, 32'h4100_0000, 32'h4080_0000, 32'h4040_0000,
              32'h7F80_0000, 32'h8000_0000, 32'h4100_0000, 32'h4100_0000};
    row_exp = '{32'h3E00_0000, 32'h3E00_0000, 32'h3E80_0000, 32'h3EAA_AAAB,
                32'h0000_0000, 32'h0000_0000, 32'h3E00_0000, 32'h3E00_0000};
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        e_mem[i][j] = 32'h3F80_0000;
        exp_p[i][j] = row_exp[i];
      end
    foreach (vecs[v]) begin
      e_mem[vecs[v].tq][vecs[v].tk] = vecs[v].e;
      exp_p[vecs[v].tq][vecs[v].tk] = vecs[v].p;
    end
  endtask
  initial begin
    int n, e5_base, sre_base;
    vecs[0] = '{0, 0, 32'h7FC0_0000, 32'h7FC0_0000};
    vecs[1] = '{0, 1, 32'h7F80_0000, 32'h7F80_0000};
    vecs[2] = '{1, 0, 32'hC040_0000, 32'hBEC0_0000};
    vecs[3] = '{1, 1, 32'h40A0_0000, 32'h3F20_0000};
    vecs[4] = '{2, 3, 32'h4000_0000, 32'h3F00_0000};
    vecs[5] = '{3, 2, 32'h4040_0000, 32'h3F80_0000};
    vecs[6] = '{4, 4, 32'hC000_0000, 32'h8000_0000};
    vecs[7] = '{5, 5, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{6, 7, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{7, 6, 32'h4200_0000, 32'h4080_0000};
    fill_plain();
    repeat (3) @(negedge clk);
    chk("rst busy", 33'(busy), 33'd0);
    chk("rst done", 33'(done), 33'd0);
    chk("rst sum_re", 33'(sum_re), 33'd0);
    chk("rst e_re", 33'(e_re), 33'd0);
    chk("rst p_rvalid", 33'(p_rvalid), 33'd0);
    chk("rst p_rdata", 33'(p_rdata), 33'd0);
    chk("rst zero_row", 33'(zero_row), 33'd0);
    rst = 1'b0;
    start_pulse();
    chk("run1 busy", 33'(busy), 33'd1);
    wait_done("run1");
    chk("run1 zero_row", 33'(zero_row), 33'd0);
    start = 1'b0;
    @(negedge clk);
    chk_all("run1");
    fill_mixed();
    e5_base = e5_cnt;
    start_pulse();
    n = 0;
    while (!(e_re && e_tq == 3'd2 && e_tk == 3'd3) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach E[2][3]", 33'(e_re), 33'd1);
    n = 0;
    while (!dut.div_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("div done for [2][3]", 33'(dut.div_done), 33'd1);
    p_re = 1'b1;
    p_tq = 3'd2;
    p_tk = 3'd3;
    @(negedge clk);
    p_re = 1'b0;
    chk("rd/wr same cycle old", {p_rvalid, p_rdata}, {1'b1, 32'h3E00_0000});
    wait_done("run2");
    chk("run2 zero_row", 33'(zero_row), 33'h20);
    chk("run2 no e_re row5", 33'(e5_cnt - e5_base), 33'd0);
    chk_all("run2");
    e_lat = 7;
    s_lat = 4;
    start_pulse();
    wait_done("run3 slow");
    chk("run3 zero_row", 33'(zero_row), 33'h20);
    chk_all("run3");
    start_pulse();
    n = 0;
    while (!(sum_re && sum_row == 3'd3) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reach row3", 33'(sum_re), 33'd1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 33'(busy), 33'd0);
    chk("abort done", 33'(done), 33'd0);
    rst = 1'b0;
    chk("abort zero_row", 33'(zero_row), 33'd0);
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++)
        exp_p[i][j] = 32'h0;
    chk_all("after abort");
    chk("idle after abort", 33'(busy), 33'd0);
    fill_mixed();
    e_lat = 2;
    s_lat = 1;
    start_pulse();
    wait_done("restart");
    chk("restart zero_row", 33'(zero_row), 33'h20);
    chk_all("restart");
    e_lat = 1;
    sre_base = sre_cnt;
    start_pulse();
    repeat (100) @(negedge clk);
    chk("held-start busy", 33'(busy), 33'd1);
    start = 1'b1;
    wait_done("held-start");
    repeat (10) @(negedge clk);
    chk("done held", 33'(done), 33'd1);
    chk("no restart busy", 33'(busy), 33'd0);
    start = 1'b0;
    @(negedge clk);
    chk("done drops", 33'(done), 33'd0);
    repeat (20) @(negedge clk);
    chk("one run only", 33'(sre_cnt - sre_base), 33'd8);
    chk("still idle", 33'(busy), 33'd0);
    chk_all("held-start");
    chk("protocol single pulse", 33'(proto_err), 33'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
